instr_encoder: RTL

Sequential instruction encoder and program loader for the RISC-V core. It accepts decoded instruction fields (class, registers, funct, immediate) over a valid/ready stream and packs them into 32-bit RV32I words. The packed words go to the instruction memory write port at consecutive word addresses. This is the inverse of the opcode decode path: words it writes must decode to the same ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/ALUOp/Branch behaviour the fields describe.

---
 rtl/instr_encoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
// Packs decoded instruction fields into 32-bit RV32I words and streams them
// into instruction memory at consecutive word addresses, one word per cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_start, load_end       session open/restart and close pulses
//   in_valid / in_ready        field bundle handshake
//   in_class                   0=R 1=I-ALU 2=LW 3=SW 4=BEQ, 5..7 illegal
//   in_rd, in_rs1, in_rs2      register indices
//   in_funct3, in_funct7       function fields (R / I classes)
//   in_imm                     signed immediate (13-bit byte offset for BEQ)
//   imem_we/addr/wdata         instruction memory write port
//   busy                       session open (LOAD or FULL)
//   word_count                 words written in the current or last session
//   err_illegal                sticky illegal-class flag, cleared by load_start
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    state_t          state;
    state_t          state_next;
    logic [ADDR_W:0] legal_count;
    logic            accept;
    logic            is_legal;
    logic            last_beat;
    logic [31:0]     enc_word;

    // Ready is withheld during control pulses so a beat never straddles a
    // session boundary.
    assign in_ready  = (state == LOAD) && !load_start && !load_end
                       && (legal_count < DEPTH_CNT);
    assign accept    = in_valid && in_ready;
    assign is_legal  = (in_class <= 3'd4);
    assign last_beat = accept && is_legal
                       && ((legal_count + (ADDR_W + 1)'(1)) == DEPTH_CNT);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // load_start takes priority over load_end and over filling up.
    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = LOAD;
        end else if (load_end && (state != IDLE)) begin
            state_next = IDLE;
        end else if ((state == LOAD) && last_beat) begin
            state_next = FULL;
        end
    end

    // Field packing; BEQ drops imm[0] since branch offsets are halfword aligned.
    always_comb begin
        enc_word = '0;
        unique case (in_class)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            3'd2: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
            3'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                              in_imm[4:0], OP_STORE};
            3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                              in_imm[4:1], in_imm[11], OP_BR};
            default: enc_word = '0;
        endcase
    end

    // Write port and counters. word_count advances at the end of the cycle in
    // which a write is actually issued, so a write pending across a restart
    // is still counted in the new session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            word_count  <= '0;
            legal_count <= '0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= accept && is_legal;
            if (accept && is_legal) begin
                imem_addr  <= BASE_ADDR + legal_count[ADDR_W-1:0];
                imem_wdata <= enc_word;
            end

            word_count <= (load_start ? '0 : word_count)
                          + {{ADDR_W{1'b0}}, imem_we};

            if (load_start) begin
                legal_count <= '0;
            end else if (accept && is_legal) begin
                legal_count <= legal_count + (ADDR_W + 1)'(1);
            end

            if (load_start) begin
                err_illegal <= 1'b0;
            end else if (accept && !is_legal) begin
                err_illegal <= 1'b1;
            end
        end
    end

endmodule
